// File: rtl/pwm_regbank_pkg.sv
// Shared types and constants for the PWM compare-register bank.
// The bank holds a two-state commit FSM and the per-channel byte-lane offsets.
package pwm_regbank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  localparam logic [1:0] OFS_B0  = 2'd0;
  localparam logic [1:0] OFS_B1  = 2'd1;
  localparam logic [1:0] OFS_B2  = 2'd2;
  localparam logic [1:0] OFS_RSV = 2'd3;

  function automatic int unsigned commit_addr(input int unsigned nch);
    return 4 * nch;
  endfunction

endpackage

// File: rtl/pwm_chan_regs.sv
// One channel of the compare bank: byte-writable scratch, staged copy and
// the active compare value driven to the PWM core.
module pwm_chan_regs
  import pwm_regbank_pkg::*;
#(
  parameter int unsigned          PWMWIDTH  = 20,
  parameter logic [PWMWIDTH-1:0]  RESET_CMP = 20'hA0002
) (
  input  logic                clk1d,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [1:0]          wr_ofs,
  input  logic [7:0]          wr_data,
  input  logic                stage,
  input  logic                load_staged,
  input  logic                load_scratch,
  output logic [PWMWIDTH-1:0] cmp
);

  localparam int unsigned HIW = PWMWIDTH - 16;

  logic [PWMWIDTH-1:0] scratch_q, scratch_d;
  logic [PWMWIDTH-1:0] staged_q, staged_d;
  logic [PWMWIDTH-1:0] active_q, active_d;

  always_comb begin
    scratch_d = scratch_q;
    if (wr_en) begin
      case (wr_ofs)
        OFS_B0:  scratch_d[7:0]           = wr_data;
        OFS_B1:  scratch_d[15:8]          = wr_data;
        OFS_B2:  scratch_d[PWMWIDTH-1:16] = wr_data[HIW-1:0];
        default: scratch_d                = scratch_q;
      endcase
    end
  end

  // Staging and commit both read the pre-edge registers, so a same-cycle
  // stage + staged-commit moves the old staged value into active.
  always_comb begin
    staged_d = stage ? scratch_q : staged_q;
    active_d = active_q;
    if (load_scratch) begin
      active_d = scratch_q;
    end else if (load_staged) begin
      active_d = staged_q;
    end
  end

  always_ff @(posedge clk1d or posedge rst) begin
    if (rst) begin
      scratch_q <= RESET_CMP;
      staged_q  <= RESET_CMP;
      active_q  <= RESET_CMP;
    end else begin
      scratch_q <= scratch_d;
      staged_q  <= staged_d;
      active_q  <= active_d;
    end
  end

  assign cmp = active_q;

endmodule

// File: rtl/pwm_regbank.sv
// Multi-channel triple-buffered compare bank: address decode, commit FSM and
// pulse outputs; commits update every channel's active value on the same edge.
module pwm_regbank
  import pwm_regbank_pkg::*;
#(
  parameter int unsigned          NCH       = 2,
  parameter int unsigned          PWMWIDTH  = 20,
  parameter int unsigned          REGBITS   = 5,
  parameter logic [PWMWIDTH-1:0]  RESET_CMP = 20'hA0002
) (
  input  logic                    clk1d,
  input  logic                    rst,
  input  logic [REGBITS-1:0]      reg_addr,
  input  logic [7:0]              reg_data,
  input  logic                    reg_valid,
  input  logic                    period_start,
  output logic [NCH*PWMWIDTH-1:0] cmp,
  output logic                    commit_pending,
  output logic                    commit_done,
  output logic                    err_addr
);

  localparam logic [REGBITS-1:0] COMMIT_ADDR = REGBITS'(commit_addr(NCH));

  state_e state_q, state_d;
  logic   commit_done_q, commit_done_d;
  logic   err_addr_q, err_addr_d;

  logic   in_chan_range;
  logic   wr_commit;
  logic   wr_imm;
  logic   stage;
  logic   load_staged;
  logic   load_scratch;

  assign in_chan_range = (reg_addr < COMMIT_ADDR);
  assign wr_commit     = reg_valid && (reg_addr == COMMIT_ADDR);
  assign wr_imm        = wr_commit && reg_data[0];

  always_ff @(posedge clk1d or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_commit && !wr_imm) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (wr_imm) begin
          state_d = IDLE;
        end else if (wr_commit) begin
          state_d = ARMED;
        end else if (period_start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An immediate commit outranks a coincident period-boundary commit.
  always_comb begin
    stage         = wr_commit;
    load_scratch  = wr_imm;
    load_staged   = (state_q == ARMED) && period_start && !wr_imm;
    commit_done_d = load_scratch || load_staged;
    err_addr_d    = reg_valid &&
                    ((reg_addr > COMMIT_ADDR) ||
                     (in_chan_range && (reg_addr[1:0] == OFS_RSV)));
  end

  always_ff @(posedge clk1d or posedge rst) begin
    if (rst) begin
      commit_done_q <= 1'b0;
      err_addr_q    <= 1'b0;
    end else begin
      commit_done_q <= commit_done_d;
      err_addr_q    <= err_addr_d;
    end
  end

  assign commit_pending = (state_q == ARMED);
  assign commit_done    = commit_done_q;
  assign err_addr       = err_addr_q;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      logic chan_we;

      assign chan_we = reg_valid && in_chan_range &&
                       (reg_addr[REGBITS-1:2] == (REGBITS-2)'(gi));

      pwm_chan_regs #(
        .PWMWIDTH  (PWMWIDTH),
        .RESET_CMP (RESET_CMP)
      ) u_chan (
        .clk1d        (clk1d),
        .rst          (rst),
        .wr_en        (chan_we),
        .wr_ofs       (reg_addr[1:0]),
        .wr_data      (reg_data),
        .stage        (stage),
        .load_staged  (load_staged),
        .load_scratch (load_scratch),
        .cmp          (cmp[gi*PWMWIDTH +: PWMWIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pwm_regbank.sv
// Self-checking bench for pwm_regbank: directed vector table, randomized
// traffic against a register-level reference model, and a reset-while-armed case.
module tb_pwm_regbank;

  localparam int NCH      = 2;
  localparam int PWMWIDTH = 20;
  localparam int REGBITS  = 5;
  localparam logic [19:0] RST_VAL = 20'hA0002;

  logic                    clk1d = 1'b0;
  logic                    rst = 1'b1;
  logic [REGBITS-1:0]      reg_addr = '0;
  logic [7:0]              reg_data = '0;
  logic                    reg_valid = 1'b0;
  logic                    period_start = 1'b0;
  logic [NCH*PWMWIDTH-1:0] cmp;
  logic                    commit_pending;
  logic                    commit_done;
  logic                    err_addr;

  pwm_regbank #(
    .NCH       (NCH),
    .PWMWIDTH  (PWMWIDTH),
    .REGBITS   (REGBITS),
    .RESET_CMP (RST_VAL)
  ) dut (
    .clk1d          (clk1d),
    .rst            (rst),
    .reg_addr       (reg_addr),
    .reg_data       (reg_data),
    .reg_valid      (reg_valid),
    .period_start   (period_start),
    .cmp            (cmp),
    .commit_pending (commit_pending),
    .commit_done    (commit_done),
    .err_addr       (err_addr)
  );

  always #5 clk1d = ~clk1d;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  // Reference model: plain arrays updated from the register-map rules.
  logic [19:0] m_scr [NCH];
  logic [19:0] m_stg [NCH];
  logic [19:0] m_act [NCH];
  bit          m_pend, m_done, m_err;

  typedef struct {
    bit          valid;
    int          addr;
    logic [7:0]  data;
    bit          ps;
    logic [19:0] c0;
    logic [19:0] c1;
    bit          pend;
    bit          done;
    bit          err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_scr[c] = RST_VAL;
      m_stg[c] = RST_VAL;
      m_act[c] = RST_VAL;
    end
    m_pend = 0;
    m_done = 0;
    m_err  = 0;
  endtask

  task automatic model_step(input bit v, input int a, input logic [7:0] d, input bit ps);
    logic [19:0] old_stg [NCH];
    bit is_commit;
    is_commit = v && (a == 4 * NCH);
    m_done = 0;
    m_err  = 0;
    for (int c = 0; c < NCH; c++) old_stg[c] = m_stg[c];
    if (is_commit) begin
      for (int c = 0; c < NCH; c++) m_stg[c] = m_scr[c];
      if (d[0]) begin
        for (int c = 0; c < NCH; c++) m_act[c] = m_scr[c];
        m_pend = 0;
        m_done = 1;
      end else begin
        if (m_pend && ps) begin
          for (int c = 0; c < NCH; c++) m_act[c] = old_stg[c];
          m_done = 1;
        end
        m_pend = 1;
      end
    end else if (m_pend && ps) begin
      for (int c = 0; c < NCH; c++) m_act[c] = m_stg[c];
      m_pend = 0;
      m_done = 1;
    end
    if (v && a < 4 * NCH) begin
      case (a % 4)
        0: m_scr[a / 4][7:0]   = d;
        1: m_scr[a / 4][15:8]  = d;
        2: m_scr[a / 4][19:16] = d[3:0];
        default: m_err = 1;
      endcase
    end else if (v && a > 4 * NCH) begin
      m_err = 1;
    end
  endtask

  function automatic logic [NCH*PWMWIDTH-1:0] model_cmp();
    logic [NCH*PWMWIDTH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*PWMWIDTH +: PWMWIDTH] = m_act[c];
    return r;
  endfunction

  // Drive one transaction, let the edge sample it, then settle before checking.
  task automatic cyc(input bit v, input int a, input logic [7:0] d, input bit ps);
    reg_valid    = v;
    reg_addr     = REGBITS'(a);
    reg_data     = d;
    period_start = ps;
    @(posedge clk1d);
    model_step(v, a, d, ps);
    #1;
    n_txn++;
    $display("txn %0d v=%0b a=%0d d=%h ps=%0b cmp=%h pend=%0b done=%0b err=%0b",
             n_txn, v, a, d, ps, cmp, commit_pending, commit_done, err_addr);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".cmp"}, 64'(cmp), 64'(model_cmp()));
    chk({tag, ".pend"}, 64'(commit_pending), 64'(m_pend));
    chk({tag, ".done"}, 64'(commit_done), 64'(m_done));
    chk({tag, ".err"}, 64'(err_addr), 64'(m_err));
  endtask

  task automatic add(input bit v, input int a, input logic [7:0] d, input bit ps,
                     input logic [19:0] c0, input logic [19:0] c1,
                     input bit p, input bit dn, input bit e);
    vec_t t;
    t.valid = v; t.addr = a; t.data = d; t.ps = ps;
    t.c0 = c0; t.c1 = c1; t.pend = p; t.done = dn; t.err = e;
    vecs.push_back(t);
  endtask

  initial begin
    // Directed vectors: expectations are hand-derived constants.
    add(0, 0, 8'h00, 0, 20'hA0002, 20'hA0002, 0, 0, 0);
    add(1, 0, 8'h34, 0, 20'hA0002, 20'hA0002, 0, 0, 0);
    add(1, 1, 8'h12, 0, 20'hA0002, 20'hA0002, 0, 0, 0);
    add(1, 2, 8'h0F, 0, 20'hA0002, 20'hA0002, 0, 0, 0);
    add(1, 8, 8'h00, 0, 20'hA0002, 20'hA0002, 1, 0, 0);
    add(0, 0, 8'h00, 1, 20'hF1234, 20'hA0002, 0, 1, 0);
    add(0, 0, 8'h00, 0, 20'hF1234, 20'hA0002, 0, 0, 0);
    add(0, 0, 8'h00, 1, 20'hF1234, 20'hA0002, 0, 0, 0);
    add(1, 4, 8'h55, 0, 20'hF1234, 20'hA0002, 0, 0, 0);
    add(1, 5, 8'h00, 0, 20'hF1234, 20'hA0002, 0, 0, 0);
    add(1, 6, 8'h00, 0, 20'hF1234, 20'hA0002, 0, 0, 0);
    add(1, 8, 8'h00, 0, 20'hF1234, 20'hA0002, 1, 0, 0);
    add(1, 4, 8'hAA, 0, 20'hF1234, 20'hA0002, 1, 0, 0);
    add(1, 8, 8'h00, 0, 20'hF1234, 20'hA0002, 1, 0, 0);
    add(1, 4, 8'h77, 0, 20'hF1234, 20'hA0002, 1, 0, 0);
    add(0, 0, 8'h00, 1, 20'hF1234, 20'h000AA, 0, 1, 0);
    add(0, 0, 8'h00, 0, 20'hF1234, 20'h000AA, 0, 0, 0);
    add(1, 3, 8'hFF, 0, 20'hF1234, 20'h000AA, 0, 0, 1);
    add(1, 9, 8'hFF, 0, 20'hF1234, 20'h000AA, 0, 0, 1);
    add(0, 0, 8'h00, 0, 20'hF1234, 20'h000AA, 0, 0, 0);
    add(1, 8, 8'h00, 0, 20'hF1234, 20'h000AA, 1, 0, 0);
    add(1, 4, 8'h11, 0, 20'hF1234, 20'h000AA, 1, 0, 0);
    add(1, 8, 8'h00, 1, 20'hF1234, 20'h00077, 1, 1, 0);
    add(0, 0, 8'h00, 0, 20'hF1234, 20'h00077, 1, 0, 0);
    add(1, 4, 8'h22, 0, 20'hF1234, 20'h00077, 1, 0, 0);
    add(1, 8, 8'h01, 1, 20'hF1234, 20'h00022, 0, 1, 0);
    add(0, 0, 8'h00, 0, 20'hF1234, 20'h00022, 0, 0, 0);
    add(1, 0, 8'h56, 0, 20'hF1234, 20'h00022, 0, 0, 0);
    add(1, 8, 8'h01, 0, 20'hF1256, 20'h00022, 0, 1, 0);
    add(1, 2, 8'hA3, 0, 20'hF1256, 20'h00022, 0, 0, 0);
    add(1, 8, 8'h01, 0, 20'h31256, 20'h00022, 0, 1, 0);
    add(0, 0, 8'h00, 0, 20'h31256, 20'h00022, 0, 0, 0);

    model_reset();
    repeat (2) @(posedge clk1d);
    #1 rst = 1'b0;
    #1;
    chk("reset.cmp", 64'(cmp), {24'h0, RST_VAL, RST_VAL});
    chk("reset.pend", 64'(commit_pending), 64'd0);
    chk("reset.done", 64'(commit_done), 64'd0);
    chk("reset.err", 64'(err_addr), 64'd0);

    foreach (vecs[i]) begin
      cyc(vecs[i].valid, vecs[i].addr, vecs[i].data, vecs[i].ps);
      chk($sformatf("vec%0d.cmp", i), 64'(cmp), 64'({vecs[i].c1, vecs[i].c0}));
      chk($sformatf("vec%0d.pend", i), 64'(commit_pending), 64'(vecs[i].pend));
      chk($sformatf("vec%0d.done", i), 64'(commit_done), 64'(vecs[i].done));
      chk($sformatf("vec%0d.err", i), 64'(err_addr), 64'(vecs[i].err));
    end

    // Randomized traffic, biased toward the COMMIT address and period boundaries.
    for (int i = 0; i < 400; i++) begin
      bit v, ps;
      int a;
      logic [7:0] d;
      v  = ($urandom_range(0, 99) < 60);
      a  = ($urandom_range(0, 99) < 25) ? 4 * NCH : int'($urandom_range(0, 11));
      d  = 8'($urandom);
      ps = ($urandom_range(0, 99) < 20);
      cyc(v, a, d, ps);
      chk_model($sformatf("rnd%0d", i));
    end

    // Reset while ARMED discards the pending commit.
    cyc(0, 0, 8'h00, 0);
    cyc(1, 0, 8'h45, 0);
    cyc(1, 1, 8'h23, 0);
    cyc(1, 2, 8'h01, 0);
    cyc(1, 4 * NCH, 8'h00, 0);
    chk("armrst.pend_before", 64'(commit_pending), 64'd1);
    reg_valid = 1'b0;
    period_start = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("armrst.cmp_async", 64'(cmp), {24'h0, RST_VAL, RST_VAL});
    chk("armrst.pend_async", 64'(commit_pending), 64'd0);
    @(posedge clk1d);
    #1 rst = 1'b0;
    cyc(0, 0, 8'h00, 1);
    chk("armrst.ps_cmp", 64'(cmp), {24'h0, RST_VAL, RST_VAL});
    chk("armrst.ps_done", 64'(commit_done), 64'd0);
    chk("armrst.ps_pend", 64'(commit_pending), 64'd0);
    cyc(0, 0, 8'h00, 0);
    chk_model("armrst.tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
